// File: rtl/pc_call_stack_if.sv
// Decoder-side bus of the minicpu program counter: control strobes in, PC and stack status out.
// The master drives the strobes; the PC (slave) drives the address and status.
interface pc_call_stack_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
);
  localparam int DW = $clog2(DEPTH + 1);

  logic             en;
  logic             ld;
  logic [WIDTH-1:0] in;
  logic             call;
  logic             ret;
  logic [WIDTH-1:0] out;
  logic [DW-1:0]    depth;
  logic             full;
  logic             empty;
  logic             ovf;
  logic             unf;

  modport master (
    output en, ld, in, call, ret,
    input  out, depth, full, empty, ovf, unf
  );

  modport slave (
    input  en, ld, in, call, ret,
    output out, depth, full, empty, ovf, unf
  );
endinterface

// File: rtl/pc_call_stack.sv
// Parametrised program counter with jump, subroutine call/return and a LIFO return stack.
// One action per enabled cycle, priority jump > call > ret > increment; all outputs registered.
module pc_call_stack #(
  parameter int               WIDTH      = 4,
  parameter int               DEPTH      = 4,
  parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
  input logic          clk,
  input logic          reset,
  pc_call_stack_if.slave bus
);
  localparam int DW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] pc_q;
  logic [DW-1:0]    cnt_q;
  logic             ovf_q;
  logic             unf_q;
  logic [WIDTH-1:0] stack_q [DEPTH];

  logic             full;
  logic             empty;
  logic [AW-1:0]    push_idx;
  logic [AW-1:0]    pop_idx;
  logic [WIDTH-1:0] pc_inc;
  logic             do_push;

  assign full     = (cnt_q == DW'(DEPTH));
  assign empty    = (cnt_q == '0);
  // The count doubles as the stack pointer: next free slot is cnt, top is cnt-1.
  assign push_idx = AW'(cnt_q);
  assign pop_idx  = AW'(cnt_q - 1'b1);
  assign pc_inc   = pc_q + 1'b1;
  assign do_push  = !reset && bus.en && bus.ld && bus.call && !full;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= RESET_ADDR;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (bus.en) begin
      if (!bus.ld) begin
        pc_q <= bus.in;
      end else if (bus.call) begin
        if (!full) begin
          pc_q  <= bus.in;
          cnt_q <= cnt_q + 1'b1;
        end else begin
          ovf_q <= 1'b1;
        end
      end else if (bus.ret) begin
        if (!empty) begin
          pc_q  <= stack_q[pop_idx];
          cnt_q <= cnt_q - 1'b1;
        end else begin
          unf_q <= 1'b1;
        end
      end else begin
        pc_q <= pc_inc;
      end
    end
  end

  // NOTE: the stack array has no reset; entries above the count are never read,
  // so clearing them would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) begin
      stack_q[push_idx] <= pc_inc;
    end
  end

  assign bus.out   = pc_q;
  assign bus.depth = cnt_q;
  assign bus.full  = full;
  assign bus.empty = empty;
  assign bus.ovf   = ovf_q;
  assign bus.unf   = unf_q;
endmodule

// File: tb/tb_pc_call_stack.sv
// Scoreboard bench for pc_call_stack: two instances (RESET_ADDR 0 and 6), WIDTH=4, DEPTH=2.
// Each scenario task pushes its expected observation when it drives a cycle and pops it after the edge.
module tb_pc_call_stack;
  logic clk;
  logic rst0;
  logic rst6;

  pc_call_stack_if #(.WIDTH(4), .DEPTH(2)) b0 ();
  pc_call_stack_if #(.WIDTH(4), .DEPTH(2)) b6 ();

  pc_call_stack #(.WIDTH(4), .DEPTH(2), .RESET_ADDR(4'h0)) dut0 (
    .clk  (clk),
    .reset(rst0),
    .bus  (b0.slave)
  );

  pc_call_stack #(.WIDTH(4), .DEPTH(2), .RESET_ADDR(4'h6)) dut6 (
    .clk  (clk),
    .reset(rst6),
    .bus  (b6.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] out;
    logic [1:0] depth;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       unf;
  } obs_t;

  typedef struct packed {
    logic       rst;
    logic       en;
    logic       ld;
    logic [3:0] in;
    logic       call;
    logic       ret;
    logic [3:0] x_out;
    logic [1:0] x_depth;
    logic       x_ovf;
    logic       x_unf;
  } step_t;

  obs_t sb [$];
  int   vectors     = 0;
  int   miscompares = 0;

  function automatic step_t mk(input logic rst, en, ld, input logic [3:0] in,
                               input logic call, ret, input logic [3:0] x_out,
                               input logic [1:0] x_depth, input logic x_ovf, x_unf);
    step_t s;
    s = '{rst, en, ld, in, call, ret, x_out, x_depth, x_ovf, x_unf};
    return s;
  endfunction

  // Expected status: full at two entries, empty at zero.
  function automatic obs_t expect_of(input step_t s);
    obs_t o;
    o.out   = s.x_out;
    o.depth = s.x_depth;
    o.full  = (s.x_depth == 2'd2);
    o.empty = (s.x_depth == 2'd0);
    o.ovf   = s.x_ovf;
    o.unf   = s.x_unf;
    return o;
  endfunction

  function automatic obs_t obs0();
    return {b0.out, b0.depth, b0.full, b0.empty, b0.ovf, b0.unf};
  endfunction

  function automatic obs_t obs6();
    return {b6.out, b6.depth, b6.full, b6.empty, b6.ovf, b6.unf};
  endfunction

  function automatic string show(input obs_t o);
    return $sformatf("out=%h depth=%0d full=%b empty=%b ovf=%b unf=%b",
                     o.out, o.depth, o.full, o.empty, o.ovf, o.unf);
  endfunction

  task automatic drive0(input step_t s);
    rst0    = s.rst;
    b0.en   = s.en;
    b0.ld   = s.ld;
    b0.in   = s.in;
    b0.call = s.call;
    b0.ret  = s.ret;
  endtask

  task automatic drive6(input step_t s);
    rst6    = s.rst;
    b6.en   = s.en;
    b6.ld   = s.ld;
    b6.in   = s.in;
    b6.call = s.call;
    b6.ret  = s.ret;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step_t tbl [$];
    obs_t  got, want;
    tbl.push_back(mk(1, 0, 1, 4'h0, 0, 0, 4'h0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 4'h5, 1, 1, 4'h0, 0, 0, 0));
    foreach (tbl[i]) begin
      drive0(tbl[i]);
      sb.push_back(expect_of(tbl[i]));
      tick();
      got  = obs0();
      want = sb.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL reset[%0d]: got %s, want %s", i, show(got), show(want));
      end
    end
  endtask

  task automatic test_count();
    step_t tbl [$];
    obs_t  got, want;
    tbl.push_back(mk(1, 0, 1, 4'h0, 0, 0, 4'h0, 0, 0, 0));
    for (int k = 1; k <= 17; k++) begin
      tbl.push_back(mk(0, 1, 1, 4'h0, 0, 0, 4'(k % 16), 0, 0, 0));
    end
    foreach (tbl[i]) begin
      drive0(tbl[i]);
      sb.push_back(expect_of(tbl[i]));
      tick();
      got  = obs0();
      want = sb.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL count[%0d]: got %s, want %s", i, show(got), show(want));
      end
    end
  endtask

  task automatic test_jump_priority();
    step_t tbl [$];
    obs_t  got, want;
    tbl.push_back(mk(1, 0, 1, 4'h0, 0, 0, 4'h0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 4'h0, 0, 0, 4'h1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 4'h0, 0, 0, 4'h2, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 4'h0, 0, 0, 4'h3, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4'h9, 1, 0, 4'h9, 0, 0, 0));  // jump beats call
    tbl.push_back(mk(0, 1, 0, 4'h2, 0, 1, 4'h2, 0, 0, 0));  // jump beats ret, no unf
    tbl.push_back(mk(0, 1, 1, 4'h0, 0, 0, 4'h3, 0, 0, 0));
    foreach (tbl[i]) begin
      drive0(tbl[i]);
      sb.push_back(expect_of(tbl[i]));
      tick();
      got  = obs0();
      want = sb.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL jump_priority[%0d]: got %s, want %s", i, show(got), show(want));
      end
    end
  endtask

  task automatic test_call_ret();
    step_t tbl [$];
    obs_t  got, want;
    tbl.push_back(mk(1, 0, 1, 4'h0, 0, 0, 4'h0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 4'h0, 0, 0, 4'h1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 4'h0, 0, 0, 4'h2, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 4'h8, 1, 0, 4'h8, 1, 0, 0));  // pushes 3
    tbl.push_back(mk(0, 1, 1, 4'h0, 0, 0, 4'h9, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 4'hC, 1, 0, 4'hC, 2, 0, 0));  // pushes A
    tbl.push_back(mk(0, 1, 1, 4'h0, 0, 1, 4'hA, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 4'h0, 0, 1, 4'h3, 0, 0, 0));
    foreach (tbl[i]) begin
      drive0(tbl[i]);
      sb.push_back(expect_of(tbl[i]));
      tick();
      got  = obs0();
      want = sb.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL call_ret[%0d]: got %s, want %s", i, show(got), show(want));
      end
    end
  endtask

  task automatic test_overflow();
    step_t tbl [$];
    obs_t  got, want;
    tbl.push_back(mk(1, 0, 1, 4'h0, 0, 0, 4'h0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 4'h8, 1, 0, 4'h8, 1, 0, 0));  // pushes 1
    tbl.push_back(mk(0, 1, 1, 4'hC, 1, 0, 4'hC, 2, 0, 0));  // pushes 9
    tbl.push_back(mk(0, 1, 1, 4'h5, 1, 0, 4'hC, 2, 1, 0));  // full: hold, ovf
    tbl.push_back(mk(0, 1, 1, 4'h0, 0, 1, 4'h9, 1, 1, 0));
    tbl.push_back(mk(0, 1, 1, 4'h0, 0, 1, 4'h1, 0, 1, 0));
    tbl.push_back(mk(0, 1, 1, 4'h0, 0, 1, 4'h1, 0, 1, 1));  // empty: hold, unf
    tbl.push_back(mk(0, 1, 1, 4'h0, 0, 0, 4'h2, 0, 1, 1));  // flags sticky
    tbl.push_back(mk(0, 0, 0, 4'h7, 1, 1, 4'h2, 0, 1, 1));  // stall
    foreach (tbl[i]) begin
      drive0(tbl[i]);
      sb.push_back(expect_of(tbl[i]));
      tick();
      got  = obs0();
      want = sb.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL overflow[%0d]: got %s, want %s", i, show(got), show(want));
      end
    end
  endtask

  task automatic test_wrap_call();
    step_t tbl [$];
    obs_t  got, want;
    tbl.push_back(mk(1, 0, 1, 4'h0, 0, 0, 4'h0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4'hF, 0, 0, 4'hF, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 4'h4, 1, 0, 4'h4, 1, 0, 0));  // pushes 0
    tbl.push_back(mk(0, 1, 1, 4'h0, 0, 1, 4'h0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 4'h7, 1, 1, 4'h7, 1, 0, 0));  // call beats ret, pushes 1
    tbl.push_back(mk(0, 1, 1, 4'h0, 0, 1, 4'h1, 0, 0, 0));
    foreach (tbl[i]) begin
      drive0(tbl[i]);
      sb.push_back(expect_of(tbl[i]));
      tick();
      got  = obs0();
      want = sb.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL wrap_call[%0d]: got %s, want %s", i, show(got), show(want));
      end
    end
  endtask

  task automatic test_back_to_back();
    step_t tbl [$];
    obs_t  got, want;
    tbl.push_back(mk(1, 0, 1, 4'h0, 0, 0, 4'h0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 4'h5, 1, 0, 4'h5, 1, 0, 0));  // pushes 1
    tbl.push_back(mk(0, 1, 1, 4'h6, 1, 0, 4'h6, 2, 0, 0));  // pushes 6
    tbl.push_back(mk(0, 1, 1, 4'h0, 0, 1, 4'h6, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 4'h2, 1, 0, 4'h2, 2, 0, 0));  // reuses slot, pushes 7
    tbl.push_back(mk(0, 1, 1, 4'h0, 0, 1, 4'h7, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 4'h0, 0, 1, 4'h1, 0, 0, 0));
    foreach (tbl[i]) begin
      drive0(tbl[i]);
      sb.push_back(expect_of(tbl[i]));
      tick();
      got  = obs0();
      want = sb.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL back_to_back[%0d]: got %s, want %s", i, show(got), show(want));
      end
    end
  endtask

  task automatic test_reset_mid_call();
    step_t tbl [$];
    obs_t  got, want;
    tbl.push_back(mk(1, 0, 1, 4'h0, 0, 0, 4'h6, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 4'h0, 0, 1, 4'h6, 0, 0, 1));
    tbl.push_back(mk(0, 1, 1, 4'hA, 1, 0, 4'hA, 1, 0, 1));
    tbl.push_back(mk(1, 1, 1, 4'h3, 1, 0, 4'h6, 0, 0, 0));  // reset beats call
    tbl.push_back(mk(0, 0, 0, 4'h1, 1, 0, 4'h6, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 4'h2, 1, 0, 4'h6, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 4'h3, 0, 1, 4'h6, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 4'h0, 0, 0, 4'h7, 0, 0, 0));
    foreach (tbl[i]) begin
      drive6(tbl[i]);
      sb.push_back(expect_of(tbl[i]));
      tick();
      got  = obs6();
      want = sb.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL reset_mid_call[%0d]: got %s, want %s", i, show(got), show(want));
      end
    end
  endtask

  initial begin
    drive0(mk(1, 0, 1, 4'h0, 0, 0, 4'h0, 0, 0, 0));
    drive6(mk(1, 0, 1, 4'h0, 0, 0, 4'h0, 0, 0, 0));
    #1;
    test_reset();
    test_count();
    test_jump_priority();
    test_call_ret();
    test_overflow();
    test_wrap_call();
    test_back_to_back();
    test_reset_mid_call();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
